// File: rtl/sm3_msg_pad.sv
// sm3_msg_pad
//   SM3 message front-end. Packs big-endian input beats into 512-bit blocks
//   and appends SM3 padding in hardware: a 0x80 byte, zero fill, and the
//   64-bit message bit-length.
//
// Parameters
//   IN_W   input beat width in bits (32, 64 or 128)
//   LEN_W  bit-length counter width (1..64), zero-extended into the length field
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           synchronous abort; drops any in-flight block
//   msg_vld_i/rdy_o   input beat handshake
//   msg_data_i        beat data, byte 0 in the top byte
//   msg_be_i          byte valid, MSB = byte 0, must be MSB-contiguous
//   msg_lst_i         beat is the last of the message
//   blk_vld_o/rdy_i   output block handshake
//   blk_data_o        512-bit block, word W0 in bits [511:480]
//   blk_lst_o         final padded block of the message
//   busy_o            message in progress
//   len_err_o         sticky bit-length overflow
//   fmt_err_o         sticky illegal byte-valid pattern
//   pad_byp_i         only with SM3_PAD_BYPASS_EN: skip padding for this message
//
// Build option: define SM3_PAD_BYPASS_EN to add pad_byp_i.

module sm3_msg_pad #(
  parameter int IN_W  = 32,
  parameter int LEN_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              msg_vld_i,
  output logic              msg_rdy_o,
  input  logic [IN_W-1:0]   msg_data_i,
  input  logic [IN_W/8-1:0] msg_be_i,
  input  logic              msg_lst_i,
  output logic              blk_vld_o,
  input  logic              blk_rdy_i,
  output logic [511:0]      blk_data_o,
  output logic              blk_lst_o,
  output logic              busy_o,
  output logic              len_err_o,
  output logic              fmt_err_o
`ifdef SM3_PAD_BYPASS_EN
  ,
  input  logic              pad_byp_i
`endif
);

  localparam int BPB   = IN_W / 8;
  localparam int NSLOT = 512 / IN_W;

  // State | meaning
  // S_FILL | collecting beats into the block register
  // S_EMIT | block presented, waiting for blk_rdy_i
  // S_PAD2 | extra padding-only block presented
  typedef enum logic [1:0] {S_FILL, S_EMIT, S_PAD2} state_e;

  state_e           state_q, state_d;
  logic [6:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [511:0]     blk_q, blk_d;
  logic             vld_q, vld_d;
  logic             lst_q, lst_d;
  logic             busy_q, busy_d;
  logic             len_err_q, len_err_d;
  logic             fmt_err_q, fmt_err_d;
  logic             pend_q, pend_d;     // a padding-only block is owed
  logic             pend80_q, pend80_d; // that block starts with 0x80
  logic             byp_eff;

  logic [6:0]       be_cnt, n_cnt, n_ptr;
  logic             be_run, be_bad, be_bad_eff;
  logic [65:0]      len_sum;
  logic             len_ovf;
  logic [LEN_W-1:0] len_new;
  logic [511:0]     merged, padded, pad2;

`ifdef SM3_PAD_BYPASS_EN
  logic byp_q;

  // The bypass choice is taken from the first beat and held for the message.
  assign byp_eff = busy_q ? byp_q : pad_byp_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byp_q <= 1'b0;
    end else if (clear_i) begin
      byp_q <= 1'b0;
    end else if (msg_vld_i && msg_rdy_o && !busy_q) begin
      byp_q <= pad_byp_i;
    end
  end
`else
  assign byp_eff = 1'b0;
`endif

  assign msg_rdy_o  = (state_q == S_FILL);
  assign blk_vld_o  = vld_q;
  assign blk_data_o = blk_q;
  assign blk_lst_o  = lst_q;
  assign busy_o     = busy_q;
  assign len_err_o  = len_err_q;
  assign fmt_err_o  = fmt_err_q;

  // Leading-ones count of the byte enables; any one after the first zero
  // breaks contiguity.
  always_comb begin
    be_cnt = '0;
    be_run = 1'b1;
    be_bad = 1'b0;
    for (int i = BPB - 1; i >= 0; i--) begin
      if (!be_run) begin
        if (msg_be_i[i]) be_bad = 1'b1;
      end else if (msg_be_i[i]) begin
        be_cnt = be_cnt + 7'd1;
      end else begin
        be_run = 1'b0;
      end
    end
    be_bad_eff = msg_lst_i ? be_bad : ~(&msg_be_i);
    n_cnt      = msg_lst_i ? be_cnt : 7'(BPB);
    n_ptr      = ptr_q + n_cnt;
    len_sum    = 66'(len_q) + 66'({n_cnt, 3'b000});
    len_ovf    = |len_sum[65:LEN_W];
    len_new    = len_sum[LEN_W-1:0];
  end

  // Non-last beats always land on a beat boundary, so the whole beat is
  // written; bytes beyond the valid count are masked off when padding.
  always_comb begin
    merged = blk_q;
    for (int s = 0; s < NSLOT; s++) begin
      if (int'(ptr_q) == s * BPB) merged[511 - s*IN_W -: IN_W] = msg_data_i;
    end
    padded = merged;
    for (int b = 0; b < 64; b++) begin
      if (b >= int'(n_ptr)) padded[511 - 8*b -: 8] = 8'h00;
      if (b == int'(n_ptr) && !byp_eff) padded[511 - 8*b -: 8] = 8'h80;
    end
    if (!byp_eff && n_ptr <= 7'd55) padded[63:0] = 64'(len_new);
    pad2 = '0;
    if (pend80_q) pad2[511:504] = 8'h80;
    pad2[63:0] = 64'(len_q);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    blk_d     = blk_q;
    vld_d     = vld_q;
    lst_d     = lst_q;
    busy_d    = busy_q;
    len_err_d = len_err_q;
    fmt_err_d = fmt_err_q;
    pend_d    = pend_q;
    pend80_d  = pend80_q;

    case (state_q)
      S_FILL: begin
        if (msg_vld_i) begin
          fmt_err_d = fmt_err_q | be_bad_eff;
          len_err_d = len_err_q | len_ovf;
          len_d     = len_new;
          busy_d    = 1'b1;
          if (!msg_lst_i) begin
            blk_d = merged;
            ptr_d = n_ptr;
            if (n_ptr == 7'd64) begin
              state_d = S_EMIT;
              vld_d   = 1'b1;
              lst_d   = 1'b0;
            end
          end else if (byp_eff && n_ptr == 7'd0) begin
            // Unpadded message ending on a block boundary: nothing to emit.
            ptr_d  = '0;
            len_d  = '0;
            busy_d = 1'b0;
          end else begin
            blk_d   = padded;
            ptr_d   = n_ptr;
            state_d = S_EMIT;
            vld_d   = 1'b1;
            if (byp_eff || n_ptr <= 7'd55) begin
              lst_d = 1'b1;
            end else begin
              lst_d    = 1'b0;
              pend_d   = 1'b1;
              pend80_d = (n_ptr == 7'd64);
            end
          end
        end
      end
      S_EMIT, S_PAD2: begin
        if (blk_rdy_i) begin
          if (lst_q) begin
            state_d = S_FILL;
            vld_d   = 1'b0;
            lst_d   = 1'b0;
            ptr_d   = '0;
            len_d   = '0;
            busy_d  = 1'b0;
          end else if (pend_q) begin
            state_d  = S_PAD2;
            blk_d    = pad2;
            lst_d    = 1'b1;
            pend_d   = 1'b0;
            pend80_d = 1'b0;
          end else begin
            state_d = S_FILL;
            vld_d   = 1'b0;
            ptr_d   = '0;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    if (clear_i) begin
      state_d   = S_FILL;
      ptr_d     = '0;
      len_d     = '0;
      blk_d     = '0;
      vld_d     = 1'b0;
      lst_d     = 1'b0;
      busy_d    = 1'b0;
      len_err_d = 1'b0;
      fmt_err_d = 1'b0;
      pend_d    = 1'b0;
      pend80_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FILL;
      ptr_q     <= '0;
      len_q     <= '0;
      blk_q     <= '0;
      vld_q     <= 1'b0;
      lst_q     <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      fmt_err_q <= 1'b0;
      pend_q    <= 1'b0;
      pend80_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      blk_q     <= blk_d;
      vld_q     <= vld_d;
      lst_q     <= lst_d;
      busy_q    <= busy_d;
      len_err_q <= len_err_d;
      fmt_err_q <= fmt_err_d;
      pend_q    <= pend_d;
      pend80_q  <= pend80_d;
    end
  end

endmodule

// File: tb/tb_sm3_msg_pad.sv
module tb_sm3_msg_pad;
  localparam int IN_W  = 32;
  localparam int LEN_W = 12;
  localparam int BPB   = IN_W / 8;

  logic              clk_i = 1'b0;
  logic              rst_i, clear_i, msg_vld_i, msg_lst_i, blk_rdy_i;
  logic              msg_rdy_o, blk_vld_o, blk_lst_o, busy_o, len_err_o, fmt_err_o;
  logic [IN_W-1:0]   msg_data_i;
  logic [BPB-1:0]    msg_be_i;
  logic [511:0]      blk_data_o;
`ifdef SM3_PAD_BYPASS_EN
  logic              pad_byp_i = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic rand_rdy = 1'b0;
  logic [511:0] cap_d[$];
  logic         cap_l[$];
  logic [511:0] exp_d[$];
  logic         exp_l[$];

  always #5 clk_i = ~clk_i;

  sm3_msg_pad #(.IN_W(IN_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .msg_vld_i(msg_vld_i), .msg_rdy_o(msg_rdy_o), .msg_data_i(msg_data_i),
    .msg_be_i(msg_be_i), .msg_lst_i(msg_lst_i),
    .blk_vld_o(blk_vld_o), .blk_rdy_i(blk_rdy_i), .blk_data_o(blk_data_o),
    .blk_lst_o(blk_lst_o), .busy_o(busy_o), .len_err_o(len_err_o), .fmt_err_o(fmt_err_o)
`ifdef SM3_PAD_BYPASS_EN
    , .pad_byp_i(pad_byp_i)
`endif
  );

  // Record every accepted block (clear_i cancels the transfer).
  always @(posedge clk_i) begin
    if (!rst_i && !clear_i && blk_vld_o && blk_rdy_i) begin
      cap_d.push_back(blk_data_o);
      cap_l.push_back(blk_lst_o);
    end
  end

  always @(negedge clk_i) begin
    if (rand_rdy) blk_rdy_i = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: standard SM3 padding of a byte string, cut into 64-byte blocks.
  task automatic build_exp(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] v;
    int nb;
    exp_d.delete();
    exp_l.delete();
    p = m;
    bits = 64'((m.size() * 8) % (1 << LEN_W));
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      v = '0;
      for (int j = 0; j < 64; j++) v[511 - 8*j -: 8] = p[64*b + j];
      exp_d.push_back(v);
      exp_l.push_back(b == nb - 1);
    end
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic [BPB-1:0] be, input logic lst);
    int n;
    n = 0;
    @(negedge clk_i);
    msg_vld_i = 1'b1; msg_data_i = d; msg_be_i = be; msg_lst_i = lst;
    while (!msg_rdy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $error("FAIL beat_timeout observed=%0d expected<200", n);
    end
    @(posedge clk_i);
    #1 msg_vld_i = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input logic empty_last);
    logic [IN_W-1:0] d;
    logic [BPB-1:0]  be;
    int nbeats;
    nbeats = (m.size() + BPB - 1) / BPB;
    for (int k = 0; k < nbeats; k++) begin
      d = $urandom;
      be = '0;
      for (int j = 0; j < BPB; j++) begin
        if (k*BPB + j < m.size()) begin
          d[IN_W - 1 - 8*j -: 8] = m[k*BPB + j];
          be[BPB - 1 - j] = 1'b1;
        end
      end
      send_beat(d, be, (k == nbeats - 1) && !empty_last);
    end
    if (empty_last || nbeats == 0) send_beat($urandom, '0, 1'b1);
  endtask

  task automatic wait_last();
    int n;
    n = 0;
    while (!(cap_l.size() > 0 && cap_l[$]) && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $error("FAIL block_timeout observed=%0d expected<400", n);
    end
  endtask

  task automatic cmp_caps(input string tag);
    chk({tag, "_nblk"}, 512'(cap_d.size()), 512'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      chk($sformatf("%s_blk%0d", tag, i), cap_d[i], exp_d[i]);
      chk($sformatf("%s_lst%0d", tag, i), 512'(cap_l[i]), 512'(exp_l[i]));
    end
    chk({tag, "_busy"}, 512'(busy_o), 512'(0));
  endtask

  task automatic run_msg(input string tag, input logic [7:0] m[$], input logic empty_last);
    cap_d.delete();
    cap_l.delete();
    build_exp(m);
    send_msg(m, empty_last);
    wait_last();
    @(negedge clk_i);
    cmp_caps(tag);
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    logic [7:0]   m[$];
    logic [511:0] held;
    logic         ok;
    int           sz;
    logic         el;

    rst_i = 1'b1; clear_i = 1'b0; msg_vld_i = 1'b0; msg_lst_i = 1'b0;
    msg_data_i = '0; msg_be_i = '0; blk_rdy_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_msg_rdy", 512'(msg_rdy_o), 512'(1));
    chk("rst_blk_vld", 512'(blk_vld_o), 512'(0));
    chk("rst_blk_data", blk_data_o, 512'(0));
    chk("rst_blk_lst", 512'(blk_lst_o), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_len_err", 512'(len_err_o), 512'(0));
    chk("rst_fmt_err", 512'(fmt_err_o), 512'(0));
    rst_i = 1'b0;

    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", m, 1'b0);
    if (cap_d.size() > 0) begin
      chk("abc_w0", 512'(cap_d[0][511:480]), 512'(32'h61626380));
      chk("abc_w15", 512'(cap_d[0][31:0]), 512'(32'h00000018));
    end

    m.delete();
    for (int i = 0; i < 57; i++) m.push_back(8'($urandom));
    run_msg("len57", m, 1'b0);
    if (cap_d.size() > 1) chk("len57_w15", 512'(cap_d[1][31:0]), 512'(32'h000001C8));

    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    run_msg("len64", m, 1'b0);
    if (cap_d.size() > 1) begin
      chk("len64_w0", 512'(cap_d[1][511:480]), 512'(32'h80000000));
      chk("len64_w15", 512'(cap_d[1][31:0]), 512'(32'h00000200));
    end

    m.delete();
    run_msg("empty", m, 1'b1);

    rand_rdy = 1'b1;
    for (int t = 0; t < 12; t++) begin
      m.delete();
      sz = $urandom_range(0, 140);
      for (int i = 0; i < sz; i++) m.push_back(8'($urandom));
      el = (sz % BPB == 0) && ($urandom_range(0, 2) == 0);
      run_msg($sformatf("rnd%0d", t), m, el);
    end
    @(negedge clk_i);
    rand_rdy = 1'b0;
    blk_rdy_i = 1'b1;

    // Back-pressure on a pending block.
    cap_d.delete(); cap_l.delete();
    blk_rdy_i = 1'b0;
    send_beat(32'h61626300, 4'b1110, 1'b1);
    @(negedge clk_i);
    chk("stall_vld", 512'(blk_vld_o), 512'(1));
    held = blk_data_o;
    chk("stall_w0", 512'(held[511:480]), 512'(32'h61626380));
    msg_vld_i = 1'b1; msg_data_i = 32'h11223344; msg_be_i = '1; msg_lst_i = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (blk_data_o !== held || msg_rdy_o !== 1'b0 || blk_vld_o !== 1'b1) ok = 1'b0;
    end
    chk("stall_hold", 512'(ok), 512'(1));
    msg_vld_i = 1'b0;
    blk_rdy_i = 1'b1;
    @(negedge clk_i);
    chk("stall_one_hs", 512'(cap_d.size()), 512'(1));
    chk("stall_rdy_after", 512'(msg_rdy_o), 512'(1));
    chk("stall_busy_after", 512'(busy_o), 512'(0));

    // Clear wins over a simultaneous handshake.
    cap_d.delete(); cap_l.delete();
    blk_rdy_i = 1'b0;
    send_beat(32'h61626300, 4'b1110, 1'b1);
    @(negedge clk_i);
    clear_i = 1'b1; blk_rdy_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    chk("clr_no_xfer", 512'(cap_d.size()), 512'(0));
    chk("clr_vld", 512'(blk_vld_o), 512'(0));
    chk("clr_busy", 512'(busy_o), 512'(0));
    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc_after_clr", m, 1'b0);

    // Format errors: non-last partial beat, then sticky, then clear.
    send_beat(32'hDEADBEEF, 4'b1100, 1'b0);
    @(negedge clk_i);
    chk("fmt_set", 512'(fmt_err_o), 512'(1));
    send_beat(32'h01020304, 4'b1111, 1'b0);
    @(negedge clk_i);
    chk("fmt_sticky", 512'(fmt_err_o), 512'(1));
    pulse_clear();
    chk("fmt_cleared", 512'(fmt_err_o), 512'(0));
    chk("fmt_clr_busy", 512'(busy_o), 512'(0));

    // Non-contiguous last beat is taken as its ones-prefix (one byte).
    cap_d.delete(); cap_l.delete();
    m = '{8'hA5};
    build_exp(m);
    send_beat(32'hA5FFEE77, 4'b1010, 1'b1);
    wait_last();
    @(negedge clk_i);
    cmp_caps("fmt_last");
    chk("fmt_last_flag", 512'(fmt_err_o), 512'(1));
    pulse_clear();

    // 520 bytes = 4160 bits overflows a 12-bit counter; length wraps.
    m.delete();
    for (int i = 0; i < 520; i++) m.push_back(8'($urandom));
    run_msg("ovf", m, 1'b0);
    chk("ovf_len_err", 512'(len_err_o), 512'(1));
    pulse_clear();
    chk("ovf_len_err_clr", 512'(len_err_o), 512'(0));

`ifdef SM3_PAD_BYPASS_EN
    cap_d.delete(); cap_l.delete();
    pad_byp_i = 1'b1;
    send_beat(32'hAABBCCDD, 4'b1100, 1'b1);
    pad_byp_i = 1'b0;
    wait_last();
    @(negedge clk_i);
    chk("byp_nblk", 512'(cap_d.size()), 512'(1));
    if (cap_d.size() > 0) begin
      chk("byp_blk", cap_d[0], {32'hAABB0000, 480'd0});
      chk("byp_lst", 512'(cap_l[0]), 512'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
